// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - request/response and SRAM port bundle for dmem_port_arbiter
//
// Purpose: groups the two requester handshakes, the shared read-response
// path and the single SRAM port into one bundle.
// Modports:
//   master - requester/SRAM side: drives req_*, sram_rdata; sees ready, rsp_*, sram_*
//   slave  - arbiter side: the mirror image of master
// Signals:
//   req_valid/req_ready/req_we/req_lock [1:0], req_addr0/1 [12:0], req_wdata0/1 [31:0]
//   rsp_valid [1:0] (one-hot), rsp_rdata [31:0]
//   sram_en, sram_we, sram_addr [12:0], sram_wdata [31:0], sram_rdata [31:0]
interface dmem_port_arbiter_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_we;
   logic [1:0]  req_lock;
   logic [12:0] req_addr0;
   logic [12:0] req_addr1;
   logic [31:0] req_wdata0;
   logic [31:0] req_wdata1;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        sram_en;
   logic        sram_we;
   logic [12:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   modport master (
      output req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
      output sram_rdata,
      input  req_ready, rsp_valid, rsp_rdata,
      input  sram_en, sram_we, sram_addr, sram_wdata
   );

   modport slave (
      input  req_valid, req_we, req_lock, req_addr0, req_addr1, req_wdata0, req_wdata1,
      input  sram_rdata,
      output req_ready, rsp_valid, rsp_rdata,
      output sram_en, sram_we, sram_addr, sram_wdata
   );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-requester round-robin arbiter with locked bursts for one SRAM port
//
// Purpose: shares one port of the 8192x32 data SRAM between the host-load
// path (requester 0) and the compute load/store path (requester 1).
// Round-robin between unlocked requests; a requester may lock the port for
// consecutive beats, bounded by MAX_BURST while the other side is waiting.
// Read data is steered back to the requester that issued the read.
// Ports:
//   clk          - sole clock, shared with the SRAM
//   rst_n        - asynchronous active-low reset
//   bus          - dmem_port_arbiter_if.slave (requests, responses, SRAM port)
//   conflict_cnt - saturating count of cycles with a valid but ungranted requester
module dmem_port_arbiter #(
   parameter int unsigned MAX_BURST = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   dmem_port_arbiter_if.slave        bus,
   output logic [15:0]               conflict_cnt
);

   typedef enum logic [1:0] {
      FREE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } lock_state_t;

   localparam logic [7:0] BC_MAX = 8'(MAX_BURST);

   lock_state_t state;
   logic        lg;        // index granted on the most recent transfer
   logic [7:0]  bc;        // locked beats taken by the current owner
   logic [1:0]  rsp_tag;   // which requester the read in flight belongs to

   logic        owned;
   logic        own_idx;
   logic        keep_lock; // owner is granted this cycle
   logic [1:0]  gnt;
   logic        gidx;
   logic        xfer;

   always_comb begin
      owned     = (state != FREE);
      own_idx   = (state == OWN1);
      gnt       = 2'b00;
      keep_lock = 1'b0;
      if (owned && bus.req_valid[own_idx] &&
          !(bc == BC_MAX && bus.req_valid[~own_idx])) begin
         keep_lock    = 1'b1;
         gnt[own_idx] = 1'b1;
      end else if (owned && bus.req_valid[own_idx]) begin
         // Burst limit reached while the other side waits: hand it one beat.
         gnt[~own_idx] = 1'b1;
      end else begin
         // Unlocked, or the owner dropped valid and so releases this cycle.
         case (bus.req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = lg ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
      // Nothing is accepted while reset is held.
      if (!rst_n) begin
         gnt       = 2'b00;
         keep_lock = 1'b0;
      end
   end

   assign gidx = gnt[1];
   assign xfer = |gnt;

   assign bus.req_ready  = gnt;
   assign bus.sram_en    = xfer;
   assign bus.sram_we    = xfer ? bus.req_we[gidx] : 1'b0;
   assign bus.sram_addr  = !xfer ? 13'd0 : (gidx ? bus.req_addr1 : bus.req_addr0);
   assign bus.sram_wdata = !xfer ? 32'd0 : (gidx ? bus.req_wdata1 : bus.req_wdata0);
   assign bus.rsp_valid  = rsp_tag;
   assign bus.rsp_rdata  = (|rsp_tag) ? bus.sram_rdata : 32'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FREE;
         bc           <= 8'd0;
         lg           <= 1'b1;
         rsp_tag      <= 2'b00;
         conflict_cnt <= 16'd0;
      end else begin
         rsp_tag <= gnt & ~bus.req_we;
         if (xfer) begin
            lg <= gidx;
         end
         if ((|(bus.req_valid & ~gnt)) && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
         end
         if (keep_lock) begin
            if (bus.req_lock[own_idx]) begin
               if (bc != BC_MAX) begin
                  bc <= bc + 8'd1;
               end
            end else begin
               state <= FREE;
               bc    <= 8'd0;
            end
         end else if (xfer && bus.req_lock[gidx]) begin
            state <= gidx ? OWN1 : OWN0;
            bc    <= 8'd1;
         end else begin
            state <= FREE;
            bc    <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;
   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] conflict_cnt;
   int          checks = 0;
   int          failures = 0;

   dmem_port_arbiter_if bus();

   dmem_port_arbiter #(.MAX_BURST(MAXB)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus.slave),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input logic [12:0] a);
      return 32'hA5A5_0000 | 32'(a);
   endfunction

   // SRAM behaviour: registered read, write visible to the next read.
   logic [31:0] sram_mem [logic [12:0]];
   logic [31:0] sram_q = 32'd0;
   assign bus.sram_rdata = sram_q;
   always @(posedge clk) begin
      if (bus.sram_en) begin
         if (bus.sram_we) sram_mem[bus.sram_addr] = bus.sram_wdata;
         else sram_q <= sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr] : init_word(bus.sram_addr);
      end
   end

   // Reference model: owner index (-1 none), burst length, last winner,
   // conflict count, memory image and expected response.
   int          m_owner = -1;
   int          m_burst = 0;
   int          m_last = 1;
   int          m_cnt = 0;
   int          mg;
   logic [1:0]  m_rsp = 2'b00;
   logic [31:0] m_rdata = 32'd0;
   logic [31:0] ref_mem [logic [12:0]];

   function automatic int model_grant();
      logic [1:0] v;
      v = bus.req_valid;
      if (!rst_n) return -1;
      if (m_owner >= 0 && v[m_owner]) begin
         if (m_burst >= MAXB && v[1 - m_owner]) return 1 - m_owner;
         return m_owner;
      end
      if (v == 2'b11) return 1 - m_last;
      if (v[0]) return 0;
      if (v[1]) return 1;
      return -1;
   endfunction

   function automatic logic [12:0] addr_of(input int g);
      return (g == 1) ? bus.req_addr1 : bus.req_addr0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1; m_burst = 0; m_last = 1; m_cnt = 0;
         m_rsp = 2'b00; m_rdata = 32'd0;
      end else begin
         mg = model_grant();
         m_rsp = 2'b00;
         if ((bus.req_valid[0] && mg != 0) || (bus.req_valid[1] && mg != 1))
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
         if (mg >= 0) begin
            if (bus.req_we[mg]) ref_mem[addr_of(mg)] = (mg == 1) ? bus.req_wdata1 : bus.req_wdata0;
            else begin
               m_rsp = (mg == 1) ? 2'b10 : 2'b01;
               m_rdata = ref_mem.exists(addr_of(mg)) ? ref_mem[addr_of(mg)] : init_word(addr_of(mg));
            end
            if (mg == m_owner) begin
               if (bus.req_lock[mg]) m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
               else m_owner = -1;
            end else if (bus.req_lock[mg]) begin
               m_owner = mg; m_burst = 1;
            end else m_owner = -1;
            m_last = mg;
         end else m_owner = -1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      int g;
      logic [1:0] er;
      g = model_grant();
      er = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
      chk("model_ready", 32'(bus.req_ready), 32'(er));
      chk("model_sram_en", 32'(bus.sram_en), 32'(|er));
      if (g >= 0) begin
         chk("model_sram_we", 32'(bus.sram_we), 32'(bus.req_we[g]));
         chk("model_sram_addr", 32'(bus.sram_addr), 32'(addr_of(g)));
         if (bus.req_we[g])
            chk("model_sram_wdata", bus.sram_wdata, (g == 1) ? bus.req_wdata1 : bus.req_wdata0);
      end
      chk("model_rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
      if (m_rsp != 2'b00) chk("model_rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("model_conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
   endtask

   task automatic apply(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                        input logic [12:0] a0, input logic [12:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
      @(negedge clk);
      bus.req_valid = v; bus.req_we = we; bus.req_lock = lk;
      bus.req_addr0 = a0; bus.req_addr1 = a1; bus.req_wdata0 = d0; bus.req_wdata1 = d1;
      #1;
      model_check();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = 2'b11;
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_sram_en", 32'(bus.sram_en), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
      @(negedge clk);
      bus.req_valid = 2'b00;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        rst;
      logic [1:0]  v, we, lk;
      logic [12:0] a0, a1;
      logic [31:0] d0, d1;
      logic [1:0]  rdy, rsp;
      logic [31:0] data;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gi, beats, cyc, wait1, maxwait;
      int exp_seq [12];
      exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

      bus.req_valid = 2'b00; bus.req_we = 2'b00; bus.req_lock = 2'b00;
      bus.req_addr0 = 13'd0; bus.req_addr1 = 13'd0; bus.req_wdata0 = 32'd0; bus.req_wdata1 = 32'd0;

      // Tie after reset, then single requester write/read.
      tbl[0] = '{1'b1, 2'b11, 2'b00, 2'b00, 13'h1, 13'h2, 32'd0, 32'd0, 2'b01, 2'b00, 32'd0, 16'd0};
      tbl[1] = '{1'b0, 2'b11, 2'b00, 2'b00, 13'h1, 13'h2, 32'd0, 32'd0, 2'b10, 2'b01, 32'hA5A5_0001, 16'd1};
      tbl[2] = '{1'b0, 2'b11, 2'b00, 2'b00, 13'h1, 13'h2, 32'd0, 32'd0, 2'b01, 2'b10, 32'hA5A5_0002, 16'd2};
      tbl[3] = '{1'b0, 2'b11, 2'b00, 2'b00, 13'h1, 13'h2, 32'd0, 32'd0, 2'b10, 2'b01, 32'hA5A5_0001, 16'd3};
      tbl[4] = '{1'b0, 2'b00, 2'b00, 2'b00, 13'h1, 13'h2, 32'd0, 32'd0, 2'b00, 2'b10, 32'hA5A5_0002, 16'd4};
      tbl[5] = '{1'b1, 2'b10, 2'b10, 2'b00, 13'h0, 13'h10, 32'd0, 32'hDEAD_BEEF, 2'b10, 2'b00, 32'd0, 16'd0};
      tbl[6] = '{1'b0, 2'b10, 2'b00, 2'b00, 13'h0, 13'h10, 32'd0, 32'd0, 2'b10, 2'b00, 32'd0, 16'd0};
      tbl[7] = '{1'b0, 2'b00, 2'b00, 2'b00, 13'h0, 13'h10, 32'd0, 32'd0, 2'b00, 2'b10, 32'hDEAD_BEEF, 16'd0};

      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].rst) do_reset();
         apply(tbl[i].v, tbl[i].we, tbl[i].lk, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
         chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[i].rdy));
         chk("tbl_rsp_valid", 32'(bus.rsp_valid), 32'(tbl[i].rsp));
         if (tbl[i].rsp != 2'b00) chk("tbl_rsp_rdata", bus.rsp_rdata, tbl[i].data);
         chk("tbl_conflict_cnt", 32'(conflict_cnt), 32'(tbl[i].cnt));
      end

      // Locked 10-beat write stream from req 0 against a constantly valid req 1.
      do_reset();
      beats = 0; cyc = 0; wait1 = 0; maxwait = 0;
      while (beats < 10 && cyc < 30) begin
         apply(2'b11, 2'b01, 2'b01, 13'(32'h100 + beats), 13'h7, 32'hB000_0000 + 32'(beats), 32'd0);
         gi = bus.req_ready[1] ? 1 : (bus.req_ready[0] ? 0 : -1);
         if (cyc < 12) chk("burst_grant", 32'(gi), 32'(exp_seq[cyc]));
         if (gi == 0) beats++;
         if (gi == 1) wait1 = 0;
         else begin
            wait1++;
            if (wait1 > maxwait) maxwait = wait1;
         end
         cyc++;
      end
      chk("burst_cycles", 32'(cyc), 32'd12);
      chk("burst_max_wait_le_4", 32'(maxwait <= MAXB), 32'd1);

      // Burst past the limit while req 1 is idle, then req 1 preempts at once.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         apply(2'b01, 2'b01, 2'b01, 13'(32'h200 + i), 13'h0, 32'(i), 32'd0);
         chk("long_burst_grant", 32'(bus.req_ready), 32'h1);
      end
      apply(2'b11, 2'b01, 2'b01, 13'h220, 13'h200, 32'h55, 32'd0);
      chk("saturated_preempt", 32'(bus.req_ready), 32'h2);
      apply(2'b00, 2'b00, 2'b00, 13'h0, 13'h0, 32'd0, 32'd0);
      chk("preempt_read_rsp", bus.rsp_rdata, 32'h0000_0000);

      // Lock release by dropping valid.
      do_reset();
      apply(2'b10, 2'b10, 2'b10, 13'h30, 13'h31, 32'd0, 32'h11);
      chk("own1_grant", 32'(bus.req_ready), 32'h2);
      apply(2'b11, 2'b10, 2'b10, 13'h30, 13'h31, 32'd0, 32'h12);
      chk("own1_priority", 32'(bus.req_ready), 32'h2);
      apply(2'b01, 2'b00, 2'b00, 13'h30, 13'h31, 32'd0, 32'd0);
      chk("drop_release_grant", 32'(bus.req_ready), 32'h1);
      apply(2'b11, 2'b00, 2'b00, 13'h30, 13'h31, 32'd0, 32'd0);
      chk("free_rr_1", 32'(bus.req_ready), 32'h2);
      apply(2'b11, 2'b00, 2'b00, 13'h30, 13'h31, 32'd0, 32'd0);
      chk("free_rr_0", 32'(bus.req_ready), 32'h1);

      // Reset asserted in the cycle after a read is accepted.
      do_reset();
      apply(2'b01, 2'b00, 2'b00, 13'h5, 13'h0, 32'd0, 32'd0);
      chk("pre_reset_read", 32'(bus.req_ready), 32'h1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("midrst_sram_en", 32'(bus.sram_en), 32'd0);
      chk("midrst_ready", 32'(bus.req_ready), 32'd0);
      chk("midrst_conflict_cnt", 32'(conflict_cnt), 32'd0);
      @(posedge clk);
      #1 chk("midrst_rsp_held", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      bus.req_valid = 2'b00;
      rst_n = 1'b1;
      apply(2'b01, 2'b00, 2'b00, 13'h6, 13'h0, 32'd0, 32'd0);
      chk("post_reset_grant", 32'(bus.req_ready), 32'h1);
      apply(2'b00, 2'b00, 2'b00, 13'h0, 13'h0, 32'd0, 32'd0);
      chk("post_reset_rsp", bus.rsp_rdata, init_word(13'h6));

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         apply(2'($urandom), 2'($urandom), 2'($urandom),
               13'($urandom_range(0, 7)), 13'($urandom_range(0, 7)), $urandom, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
